memory_arbiter: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/memory_arbiter_if.sv | 44 ++++
 rtl/memory_arbiter_starve_counter.sv | 26 ++
 rtl/memory_arbiter.sv | 140 ++++++++++++++
 tb/tb_memory_arbiter.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM status and arbiter grant types
// used by the memory arbiter and the coherence debug logic.
package cpu_types_pkg;

    localparam int NCORES = 2;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DATA = 2'd1,
        GNT_I0   = 2'd2,
        GNT_I1   = 2'd3
    } grant_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: icache fetch ports, coherence data port
// and single RAM port seen by the arbiter.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic [NCORES-1:0] iREN;
    word_t [NCORES-1:0] iaddr;
    logic [NCORES-1:0] iwait;
    word_t [NCORES-1:0] iload;

    logic dREN;
    logic dWEN;
    word_t daddr;
    word_t dstore;
    logic dwait;
    word_t dload;

    logic ramREN;
    logic ramWEN;
    word_t ramaddr;
    word_t ramstore;
    word_t ramload;
    ramstate_t ramstate;

    grant_t grant;
    logic err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore,
        output grant, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  grant, err
    );

endinterface

// File: rtl/memory_arbiter_starve_counter.sv
// starve_counter: saturating count of data completions made while
// an instruction fetch was waiting.
module starve_counter #(
    parameter int STARVE_LIMIT = 8,
    localparam int W = $clog2(STARVE_LIMIT + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [W-1:0] count;

    assign sat = (count == W'(STARVE_LIMIT));

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: single-port RAM arbiter, data first, icaches
// round-robin, with a forced fetch after a run of data grants.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input logic CLK,
    input logic RST,
    memory_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DGNT, IGNT} arb_state_t;

    arb_state_t state, nextState;
    grant_t grant, nextGrant;
    logic rr, nextRr;
    logic err, nextErr;
    logic dReq, iReq, core, pick;
    logic ramDone, ramErr;
    logic starveInc, starveClr, starveSat;

    starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) starveCnt (
        .CLK(CLK),
        .RST(RST),
        .inc(starveInc),
        .clr(starveClr),
        .sat(starveSat)
    );

    assign dReq = bus.dREN | bus.dWEN;
    assign iReq = |bus.iREN;
    assign core = grant[0];
    assign pick = bus.iREN[rr] ? rr : !rr;
    assign ramDone = (bus.ramstate == ACCESS);
    assign ramErr = (bus.ramstate == ERROR);
    assign bus.grant = grant;
    assign bus.err = err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            grant <= GNT_NONE;
            rr <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= nextState;
            grant <= nextGrant;
            rr <= nextRr;
            err <= nextErr;
        end
    end

    always_comb begin
        nextState = state;
        nextGrant = grant;
        nextRr = rr;
        nextErr = err;
        starveInc = 1'b0;
        starveClr = 1'b0;
        bus.iwait = '1;
        bus.iload = '0;
        bus.dwait = 1'b1;
        bus.dload = '0;
        bus.ramREN = 1'b0;
        bus.ramWEN = 1'b0;
        bus.ramaddr = '0;
        bus.ramstore = '0;
        unique case (state)
            IDLE: begin
                nextGrant = GNT_NONE;
                if (dReq && !(iReq && starveSat)) begin
                    nextState = DGNT;
                    nextGrant = GNT_DATA;
                end else if (iReq) begin
                    nextState = IGNT;
                    nextGrant = pick ? GNT_I1 : GNT_I0;
                end
            end
            DGNT: begin
                if (!dReq) begin
                    nextState = IDLE;
                    nextGrant = GNT_NONE;
                end else begin
                    // a write strobe suppresses the read strobe
                    bus.ramWEN = bus.dWEN;
                    bus.ramREN = !bus.dWEN;
                    bus.ramaddr = bus.daddr;
                    bus.ramstore = bus.dstore;
                    unique case (1'b1)
                        ramDone: begin
                            bus.dwait = 1'b0;
                            bus.dload = bus.ramload;
                            starveInc = iReq;
                            starveClr = !iReq;
                            nextState = IDLE;
                            nextGrant = GNT_NONE;
                        end
                        ramErr: begin
                            nextErr = 1'b1;
                            nextState = IDLE;
                            nextGrant = GNT_NONE;
                        end
                        default: ;
                    endcase
                end
            end
            IGNT: begin
                if (!bus.iREN[core]) begin
                    nextState = IDLE;
                    nextGrant = GNT_NONE;
                end else begin
                    bus.ramREN = 1'b1;
                    bus.ramaddr = bus.iaddr[core];
                    unique case (1'b1)
                        ramDone: begin
                            bus.iwait[core] = 1'b0;
                            bus.iload[core] = bus.ramload;
                            nextRr = !core;
                            starveClr = 1'b1;
                            nextState = IDLE;
                            nextGrant = GNT_NONE;
                        end
                        ramErr: begin
                            nextErr = 1'b1;
                            nextState = IDLE;
                            nextGrant = GNT_NONE;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                nextState = IDLE;
                nextGrant = GNT_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic
// against a transaction-level arbitration model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int LIM = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int tests = 0;
    int fails = 0;
    int busyN = 0;
    bit errInject = 1'b0;
    word_t ramMem[word_t];
    word_t refMem[word_t];

    memory_arbiter_if bus();

    memory_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    function automatic word_t initword(word_t a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic word_t refword(word_t a);
        return refMem.exists(a) ? refMem[a] : initword(a);
    endfunction

    // RAM: busyN BUSY cycles after strobes appear, then ACCESS/ERROR
    initial begin
        int cnt;
        cnt = 0;
        bus.ramstate = FREE;
        bus.ramload = '0;
        forever begin
            @(negedge CLK);
            if (bus.ramREN || bus.ramWEN) begin
                if (cnt >= busyN) begin
                    cnt = 0;
                    if (errInject) begin
                        bus.ramstate = ERROR;
                        bus.ramload = 32'hE0E0E0E0;
                    end else begin
                        bus.ramstate = ACCESS;
                        bus.ramload = ramMem.exists(bus.ramaddr)
                            ? ramMem[bus.ramaddr] : initword(bus.ramaddr);
                        if (bus.ramWEN) ramMem[bus.ramaddr] = bus.ramstore;
                    end
                end else begin
                    cnt++;
                    bus.ramstate = BUSY;
                    bus.ramload = 32'hBAD00000 + word_t'(cnt);
                end
            end else begin
                cnt = 0;
                bus.ramstate = FREE;
                bus.ramload = 32'hBAD0FFFF;
            end
        end
    end

    task automatic do_reset();
        RST = 1'b1;
        bus.iREN = '0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        errInject = 1'b0;
        busyN = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic wait_done(output int who, output word_t ld,
                             output int cyc, output bit ok);
        ok = 1'b0;
        who = 0;
        ld = '0;
        cyc = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge CLK);
            #1;
            cyc++;
            if (!bus.dwait) begin
                who = 1; ld = bus.dload; ok = 1'b1;
            end else if (!bus.iwait[0]) begin
                who = 2; ld = bus.iload[0]; ok = 1'b1;
            end else if (!bus.iwait[1]) begin
                who = 3; ld = bus.iload[1]; ok = 1'b1;
            end
            if (ok) break;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.iREN = 2'b11;
        bus.dREN = 1'b1;
        bus.dWEN = 1'b0;
        bus.daddr = 32'h8;
        busyN = 5;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1;
        tests++;
        if (bus.grant !== GNT_NONE || bus.err !== 1'b0) begin
            fails++;
            $display("FAIL reset_grant_err: got %0d/%0b want 0/0",
                     bus.grant, bus.err);
        end
        tests++;
        if (bus.iwait !== 2'b11 || bus.dwait !== 1'b1) begin
            fails++;
            $display("FAIL reset_waits: got %b/%b want 11/1",
                     bus.iwait, bus.dwait);
        end
        tests++;
        if (bus.iload !== '0 || bus.dload !== '0) begin
            fails++;
            $display("FAIL reset_loads: got %0h/%0h want 0/0",
                     bus.iload, bus.dload);
        end
        tests++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== '0) begin
            fails++;
            $display("FAIL reset_ram: got %b%b %0h %0h want all 0",
                     bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
        end
        @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        tests++;
        if (bus.grant !== GNT_DATA || bus.ramREN !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_grant: got %0d/%b want 1/1",
                     bus.grant, bus.ramREN);
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        tests++;
        if (bus.ramREN !== 1'b0 || bus.grant !== GNT_NONE) begin
            fails++;
            $display("FAIL reset_mid_txn: got %b/%0d want 0/0",
                     bus.ramREN, bus.grant);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        int who, cyc, exp;
        word_t ld;
        bit ok;
        do_reset();
        busyN = 2;
        bus.iaddr[0] = 32'h40;
        bus.iaddr[1] = 32'h80;
        bus.iREN = 2'b11;
        exp = 2;
        for (int k = 0; k < 4; k++) begin
            wait_done(who, ld, cyc, ok);
            tests++;
            if (!ok || who !== exp) begin
                fails++;
                $display("FAIL rr_owner[%0d]: got %0d want %0d", k, who, exp);
            end
            tests++;
            if (ld !== refword(bus.iaddr[exp-2])) begin
                fails++;
                $display("FAIL rr_load[%0d]: got %0h want %0h",
                         k, ld, refword(bus.iaddr[exp-2]));
            end
            tests++;
            if (cyc !== busyN + 2) begin
                fails++;
                $display("FAIL rr_latency[%0d]: got %0d want %0d",
                         k, cyc, busyN + 2);
            end
            @(posedge CLK);
            #1;
            tests++;
            if (bus.iwait !== 2'b11) begin
                fails++;
                $display("FAIL rr_pulse[%0d]: got %b want 11", k, bus.iwait);
            end
            exp = (exp == 2) ? 3 : 2;
        end
        bus.iREN = '0;
    endtask

    task automatic test_starvation();
        int who, cyc, exp, sc;
        word_t ld, a;
        bit ok;
        do_reset();
        busyN = 0;
        bus.daddr = 32'h200;
        bus.iaddr[0] = 32'h300;
        bus.dREN = 1'b1;
        bus.iREN = 2'b01;
        sc = 0;
        for (int k = 0; k < 11; k++) begin
            if (sc == LIM) begin
                exp = 2; sc = 0; a = bus.iaddr[0];
            end else begin
                exp = 1; sc++; a = bus.daddr;
            end
            wait_done(who, ld, cyc, ok);
            tests++;
            if (!ok || who !== exp || ld !== refword(a)) begin
                fails++;
                $display("FAIL starve[%0d]: got %0d/%0h want %0d/%0h",
                         k, who, ld, exp, refword(a));
            end
        end
        @(posedge CLK);
        #1;
        bus.dREN = 1'b0;
        bus.iREN = '0;
    endtask

    task automatic test_write();
        int lows, who, cyc;
        word_t ld;
        bit ok;
        do_reset();
        busyN = 3;
        bus.daddr = 32'h100;
        bus.dstore = 32'hDEADBEEF;
        bus.dWEN = 1'b1;
        lows = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            #1;
            if (bus.grant == GNT_DATA) begin
                tests++;
                if ({bus.ramWEN, bus.ramREN} !== 2'b10 ||
                    bus.ramaddr !== 32'h100 ||
                    bus.ramstore !== 32'hDEADBEEF) begin
                    fails++;
                    $display("FAIL write_strobes: got %b%b %0h %0h",
                             bus.ramWEN, bus.ramREN, bus.ramaddr,
                             bus.ramstore);
                end
            end
            if (!bus.dwait) begin
                lows++;
                break;
            end
        end
        @(posedge CLK);
        #1 bus.dWEN = 1'b0;
        refMem[32'h100] = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            #1;
            if (!bus.dwait) lows++;
        end
        tests++;
        if (lows !== 1) begin
            fails++;
            $display("FAIL write_dwait_pulses: got %0d want 1", lows);
        end
        bus.dREN = 1'b1;
        wait_done(who, ld, cyc, ok);
        tests++;
        if (!ok || who !== 1 || ld !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_readback: got %0d/%0h want 1/deadbeef",
                     who, ld);
        end
        @(posedge CLK);
        #1 bus.dREN = 1'b0;
    endtask

    task automatic test_error();
        int who, cyc;
        word_t ld;
        bit ok, seen;
        do_reset();
        busyN = 1;
        bus.iaddr[0] = 32'h44;
        bus.iREN = 2'b01;
        errInject = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            #1;
            if (bus.ramstate == ERROR) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen || bus.iwait[0] !== 1'b1 || bus.iload !== '0) begin
            fails++;
            $display("FAIL err_wait: got %b/%b/%0h want 1/1/0",
                     seen, bus.iwait[0], bus.iload);
        end
        errInject = 1'b0;
        @(posedge CLK);
        #1;
        tests++;
        if (bus.err !== 1'b1 || bus.grant !== GNT_NONE) begin
            fails++;
            $display("FAIL err_set: got %b/%0d want 1/0",
                     bus.err, bus.grant);
        end
        wait_done(who, ld, cyc, ok);
        tests++;
        if (!ok || who !== 2 || ld !== refword(32'h44)) begin
            fails++;
            $display("FAIL err_retry: got %0d/%0h want 2/%0h",
                     who, ld, refword(32'h44));
        end
        tests++;
        if (bus.err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: got %b want 1", bus.err);
        end
        @(posedge CLK);
        #1 bus.iREN = '0;
    endtask

    task automatic test_abort();
        int who, cyc, lows;
        word_t ld;
        bit ok;
        do_reset();
        busyN = 3;
        bus.iaddr[0] = 32'h10;
        bus.iaddr[1] = 32'h20;
        bus.iREN = 2'b01;
        wait_done(who, ld, cyc, ok);
        tests++;
        if (!ok || who !== 2) begin
            fails++;
            $display("FAIL abort_setup: got %0d want 2", who);
        end
        @(posedge CLK);
        #1 bus.iREN = 2'b10;
        @(posedge CLK);
        #1;
        tests++;
        if (bus.grant !== GNT_I1 || bus.ramREN !== 1'b1) begin
            fails++;
            $display("FAIL abort_grant: got %0d/%b want 3/1",
                     bus.grant, bus.ramREN);
        end
        @(posedge CLK);
        #1 bus.iREN = 2'b00;
        #1;
        tests++;
        if (bus.ramREN !== 1'b0 || bus.ramaddr !== '0) begin
            fails++;
            $display("FAIL abort_strobe: got %b/%0h want 0/0",
                     bus.ramREN, bus.ramaddr);
        end
        lows = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            #1;
            if (!bus.iwait[1]) lows++;
        end
        tests++;
        if (lows !== 0 || bus.grant !== GNT_NONE) begin
            fails++;
            $display("FAIL abort_nowait: got %0d/%0d want 0/0",
                     lows, bus.grant);
        end
        bus.iREN = 2'b11;
        @(posedge CLK);
        #1;
        tests++;
        if (bus.grant !== GNT_I1) begin
            fails++;
            $display("FAIL abort_rr_kept: got %0d want 3", bus.grant);
        end
        bus.iREN = '0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_random();
        int who, cyc, exp, dr, rr, sc, g;
        logic [1:0] irv;
        word_t ld, a;
        bit ok;
        do_reset();
        rr = 0;
        sc = 0;
        for (int n = 0; n < 80; n++) begin
            dr = int'($urandom_range(0, 2));
            irv = 2'($urandom_range(0, 3));
            if (dr == 0 && irv == 2'b00) irv = 2'($urandom_range(1, 3));
            busyN = int'($urandom_range(0, 2));
            bus.daddr = word_t'($urandom_range(0, 7)) << 2;
            bus.iaddr[0] = word_t'($urandom_range(0, 7)) << 2;
            bus.iaddr[1] = word_t'($urandom_range(0, 7)) << 2;
            bus.dstore = $urandom;
            bus.dREN = (dr == 1) ? 1'b1 : (dr == 2) ? 1'($urandom) : 1'b0;
            bus.dWEN = (dr == 2);
            bus.iREN = irv;
            if (dr != 0 && !(irv != 0 && sc == LIM)) begin
                exp = 1;
                a = bus.daddr;
            end else begin
                g = irv[rr] ? rr : 1 - rr;
                exp = 2 + g;
                a = bus.iaddr[g];
            end
            wait_done(who, ld, cyc, ok);
            tests++;
            if (!ok || who !== exp || cyc !== busyN + 2) begin
                fails++;
                $display("FAIL rand_owner[%0d]: got %0d@%0d want %0d@%0d",
                         n, who, cyc, exp, busyN + 2);
                break;
            end
            if (exp != 1 || dr == 1) begin
                tests++;
                if (ld !== refword(a)) begin
                    fails++;
                    $display("FAIL rand_load[%0d]: got %0h want %0h",
                             n, ld, refword(a));
                end
            end
            if (exp == 1) begin
                if (dr == 2) refMem[a] = bus.dstore;
                sc = (irv != 0) ? ((sc < LIM) ? sc + 1 : LIM) : 0;
            end else begin
                rr = 1 - g;
                sc = 0;
            end
            @(posedge CLK);
            #1;
            tests++;
            if (bus.iwait !== 2'b11 || bus.dwait !== 1'b1 ||
                bus.err !== 1'b0) begin
                fails++;
                $display("FAIL rand_idle[%0d]: got %b/%b/%b want 11/1/0",
                         n, bus.iwait, bus.dwait, bus.err);
            end
        end
        bus.iREN = '0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
    endtask

    initial begin
        bus.iREN = '0;
        bus.iaddr = '0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        bus.daddr = '0;
        bus.dstore = '0;
        test_reset();
        test_round_robin();
        test_starvation();
        test_write();
        test_error();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
